gsensor_spi_poller: RTL and testbench
=====================================

Name: gsensor_spi_poller

Overview:
- Parametrised SPI master and poller for the on-board ADXL345 accelerometer (GSENSOR pins). It configures the sensor after reset, then periodically burst-reads NUM_AXES axis registers.
- Presents signed axis samples with a one-cycle valid strobe to game logic (VGA sprite control, HEX/LED debug).
- Generalises a single fixed-axis read to configurable axis count, SCLK rate, sample rate and optional averaging.

Parameters:
- CLK_DIV, 25, i_clock cycles per SCLK half-period (≥2); 50 MHz/50 = 1 MHz SCLK.
- NUM_AXES, 3, axes read per sample (1..3: X, XY, XYZ).
- SAMPLE_PERIOD, 50000, i_clock cycles between read starts; must exceed one read transaction (checked by simulation assertion).
- DATA_FORMAT_VAL, 8'h0B, byte written to register 0x31 (full resolution, ±16 g, 4-wire SPI).

Ports:
- i_clock, input, 1, system clock (50 MHz).
- i_reset, input, 1, synchronous active-high reset.
- i_enable, input, 1, permits periodic reads; does not gate init.
- o_spi_cs_n, output, 1, chip select to o_GSENSOR_CS_n.
- o_spi_sclk, output, 1, SPI clock to o_GSENSOR_SCLK.
- o_spi_mosi, output, 1, drives io_GSENSOR_SDI.
- i_spi_miso, input, 1, from io_GSENSOR_SDO.
- o_axis_data, output, 16*NUM_AXES, axis n at [16n+15:16n], signed two's complement, X at n=0.
- o_valid, output, 1, one-cycle strobe when o_axis_data updates.
- o_init_done, output, 1, high once both config writes have completed.
- o_busy, output, 1, high while CS is asserted.

Behaviour:
- Clock and reset: one clock, i_clock; i_reset is synchronous and active-high.
- Reset values: o_spi_cs_n=1, o_spi_sclk=1, o_spi_mosi=1, o_axis_data=0, o_valid=0, o_init_done=0, o_busy=0. Reset mid-transaction aborts it on the next edge, and init restarts.
- SPI mode 3:
  - SCLK idles high.
  - CS falls, then after CLK_DIV cycles SCLK falls.
  - MOSI changes on each SCLK falling edge, MSB first.
  - MISO is sampled on each rising edge.
  - After the final rising edge, CS rises CLK_DIV cycles later.
  - CS stays high ≥2*CLK_DIV cycles between transactions.
- Command byte: bit7=R/W (1=read), bit6=MB (1 on reads, 0 on writes), bits5:0 = address.
- FSM states:
  - RESET_WAIT: hold 2*CLK_DIV cycles, then go to INIT_FMT.
  - INIT_FMT: 16-bit write, cmd 8'h31 + DATA_FORMAT_VAL; then INIT_PWR.
  - INIT_PWR: 16-bit write, cmd 8'h2D + 8'h08 (measure); then WAIT. o_init_done is set in the cycle CS rises.
  - WAIT: period counter counts. On reaching SAMPLE_PERIOD-1, if i_enable=1, go to READ and reset the counter; if i_enable=0, the counter holds at SAMPLE_PERIOD-1 and READ starts in the first cycle i_enable=1.
  - READ: cmd 8'hF2, then 16*NUM_AXES bits clocked in. Byte order per axis is low byte first; assemble as {high, low}. Return to WAIT.
- The period counter starts at 0 on entering WAIT from INIT_PWR and free-runs during READ.
- Output update: o_axis_data updates and o_valid pulses in the same cycle CS rises after READ. o_valid is never high during init.
- i_enable falling during READ: the transaction completes and o_valid still pulses.
- Transaction length: write = 16 SCLK periods; read = 8+16*NUM_AXES periods (56 for NUM_AXES=3).

Optional Feature:
- Macro GSENSOR_POLLER_AVG_EN.
- Defined:
  - Each axis accumulates 4 consecutive reads in an 18-bit signed sum.
  - On the 4th read, output = sum arithmetic-shifted right by 2 (truncate toward −∞), o_valid pulses, and the accumulators clear.
  - o_valid rate becomes 1/4 of the read rate. Reset clears the accumulators and the read count.
- Undefined: every read produces o_valid with raw data; no accumulator logic is present.

Test Plan:
- Reset, CLK_DIV=2, SPI slave model: first two transactions are MOSI 16'h310B then 16'h2D08; SCLK is high whenever CS is high. o_init_done rises in the cycle CS rises after the second write, and o_valid stays 0 throughout.
- NUM_AXES=3, slave returns bytes 34 12 CD AB 01 00:
  - MOSI command is 8'hF2 and the read is exactly 56 SCLK falling edges.
  - o_axis_data = {16'h0001, 16'hABCD, 16'h1234}.
  - One o_valid pulse, coincident with CS rising.
- SAMPLE_PERIOD=400, i_enable=1: CS falling edges of consecutive reads are exactly 400 cycles apart. With i_enable low for 1000 cycles, there are no reads; after i_enable rises, the read starts in that same cycle.
- i_reset pulsed mid-READ (bit 20): next cycle CS=1 and SCLK=1, o_init_done=0, o_axis_data=0, and the 8'h31 write restarts.
- GSENSOR_POLLER_AVG_EN defined, X reads 16'h0004, 16'h0005, 16'hFFFF, 16'h0000:
  - o_valid pulses once, after the 4th read, with X=16'h0002 (sum 8 >>> 2).
  - Reads 16'hFFFF×3 and 16'hFFFE give X=16'hFFFE (sum −5 >>> 2 = −2).

Source files
------------

// File: rtl/gsensor_spi_poller.sv
// ADXL345 SPI mode-3 master: configures the sensor, then burst-reads NUM_AXES axes every SAMPLE_PERIOD.
// Define GSENSOR_POLLER_AVG_EN to output the mean of every 4 reads instead of raw samples.
module gsensor_spi_poller #(
    parameter int unsigned CLK_DIV         = 25,
    parameter int unsigned NUM_AXES        = 3,
    parameter int unsigned SAMPLE_PERIOD   = 50000,
    parameter logic [7:0]  DATA_FORMAT_VAL = 8'h0B
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    output logic                    o_spi_cs_n,
    output logic                    o_spi_sclk,
    output logic                    o_spi_mosi,
    input  logic                    i_spi_miso,
    output logic [16*NUM_AXES-1:0]  o_axis_data,
    output logic                    o_valid,
    output logic                    o_init_done,
    output logic                    o_busy
);
    localparam int unsigned DW      = 16 * NUM_AXES;
    localparam int unsigned RD_BITS = 8 + DW;
    localparam int unsigned BW      = $clog2(RD_BITS + 1);
    localparam int unsigned CW      = $clog2(2 * CLK_DIV);
    localparam int unsigned PW      = $clog2(SAMPLE_PERIOD);

    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [BW-1:0] WR_LEN   = BW'(16);
    localparam logic [BW-1:0] RD_LEN   = BW'(RD_BITS);

    typedef enum logic [2:0] {
        S_RESET_WAIT,
        S_INIT_FMT,
        S_INIT_PWR,
        S_WAIT,
        S_READ
    } state_t;

    typedef enum logic [2:0] {
        P_IDLE,
        P_GAP,
        P_LEAD,
        P_LOW,
        P_HIGH,
        P_TRAIL
    } phase_t;

    state_t         state_q;
    phase_t         phase_q;
    logic [CW-1:0]  div_q;
    logic [BW-1:0]  bits_q;
    logic [15:0]    tx_q;
    logic [DW-1:0]  rx_q;
    logic [PW-1:0]  per_q;
    logic           cs_n_q;
    logic           sclk_q;
    logic           mosi_q;
    logic [DW-1:0]  data_q;
    logic           valid_q;
    logic           init_done_q;

    logic [DW-1:0]  rx_d;
    logic [DW-1:0]  axis_d;
    logic [DW-1:0]  pub_data_d;
    logic           pub_now_d;
    logic           xfer_done;
    logic           read_done;

    assign xfer_done = (phase_q == P_TRAIL) && (div_q == DIV_LAST);
    assign read_done = (state_q == S_READ) && xfer_done;
    assign rx_d      = {rx_q[DW-2:0], i_spi_miso};

    // The sensor sends each axis low byte first; byte 0 ends up in the top of rx_q.
    always_comb begin
        axis_d = '0;
        for (int n = 0; n < int'(NUM_AXES); n++) begin
            axis_d[16*n +: 8]   = rx_q[DW-1-16*n -: 8];
            axis_d[16*n+8 +: 8] = rx_q[DW-9-16*n -: 8];
        end
    end

`ifdef GSENSOR_POLLER_AVG_EN
    logic [18*NUM_AXES-1:0] acc_q;
    logic [18*NUM_AXES-1:0] sum_d;
    logic [DW-1:0]          avg_d;
    logic [1:0]             cnt_q;

    always_comb begin
        sum_d = '0;
        avg_d = '0;
        for (int n = 0; n < int'(NUM_AXES); n++) begin
            sum_d[18*n +: 18] = acc_q[18*n +: 18]
                              + {{2{axis_d[16*n+15]}}, axis_d[16*n +: 16]};
            avg_d[16*n +: 16] = sum_d[18*n+2 +: 16];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (read_done) begin
            if (cnt_q == 2'd3) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= sum_d;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign pub_now_d  = (cnt_q == 2'd3);
    assign pub_data_d = avg_d;
`else
    assign pub_now_d  = 1'b1;
    assign pub_data_d = axis_d;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= S_RESET_WAIT;
            phase_q     <= P_IDLE;
            div_q       <= '0;
            bits_q      <= '0;
            tx_q        <= '1;
            rx_q        <= '0;
            per_q       <= '0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            mosi_q      <= 1'b1;
            data_q      <= '0;
            valid_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            unique case (phase_q)
                P_GAP: begin
                    if (div_q == GAP_LAST) begin
                        div_q   <= '0;
                        phase_q <= P_LEAD;
                        cs_n_q  <= 1'b0;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                P_LEAD, P_HIGH: begin
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        phase_q <= P_LOW;
                        sclk_q  <= 1'b0;
                        mosi_q  <= tx_q[15];
                        tx_q    <= {tx_q[14:0], 1'b1};
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                P_LOW: begin
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        sclk_q  <= 1'b1;
                        rx_q    <= rx_d;
                        bits_q  <= bits_q - 1'b1;
                        phase_q <= (bits_q == BW'(1)) ? P_TRAIL : P_HIGH;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                P_TRAIL: begin
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        phase_q <= P_IDLE;
                        cs_n_q  <= 1'b1;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: ;
            endcase

            unique case (state_q)
                S_RESET_WAIT: begin
                    if (div_q == GAP_LAST) begin
                        state_q <= S_INIT_FMT;
                        div_q   <= '0;
                        phase_q <= P_LEAD;
                        cs_n_q  <= 1'b0;
                        bits_q  <= WR_LEN;
                        tx_q    <= {8'h31, DATA_FORMAT_VAL};
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_INIT_FMT: begin
                    if (xfer_done) begin
                        state_q <= S_INIT_PWR;
                        phase_q <= P_GAP;
                        bits_q  <= WR_LEN;
                        tx_q    <= {8'h2D, 8'h08};
                    end
                end
                S_INIT_PWR: begin
                    if (xfer_done) begin
                        state_q     <= S_WAIT;
                        per_q       <= '0;
                        init_done_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (per_q >= PER_LAST) begin
                        if (i_enable) begin
                            state_q <= S_READ;
                            per_q   <= '0;
                            div_q   <= '0;
                            phase_q <= P_LEAD;
                            cs_n_q  <= 1'b0;
                            bits_q  <= RD_LEN;
                            tx_q    <= {8'hF2, 8'hFF};
                        end
                    end else begin
                        per_q <= per_q + 1'b1;
                    end
                end
                S_READ: begin
                    if (per_q != PER_LAST) begin
                        per_q <= per_q + 1'b1;
                    end
                    if (xfer_done) begin
                        state_q <= S_WAIT;
                        if (pub_now_d) begin
                            data_q  <= pub_data_d;
                            valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_RESET_WAIT;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clock) begin
        if (!i_reset && state_q == S_READ) begin
            assert (per_q != PER_LAST)
            else $error("gsensor_spi_poller: SAMPLE_PERIOD too short for one read");
        end
    end
`endif

    assign o_spi_cs_n  = cs_n_q;
    assign o_spi_sclk  = sclk_q;
    assign o_spi_mosi  = mosi_q;
    assign o_axis_data = data_q;
    assign o_valid     = valid_q;
    assign o_init_done = init_done_q;
    assign o_busy      = ~cs_n_q;

endmodule

// File: tb/tb_gsensor_spi_poller.sv
// Bench for gsensor_spi_poller: behavioural ADXL345 slave plus scenario tasks.
module tb_gsensor_spi_poller;
    localparam int CLK_DIV = 2;
    localparam int NA = 3;
    localparam int SP = 400;

    logic clk = 1'b0;
    logic i_reset = 1'b1;
    logic i_enable = 1'b0;
    logic spi_miso = 1'b1;
    logic o_spi_cs_n, o_spi_sclk, o_spi_mosi;
    logic [16*NA-1:0] o_axis_data;
    logic o_valid, o_init_done, o_busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    gsensor_spi_poller #(
        .CLK_DIV(CLK_DIV), .NUM_AXES(NA), .SAMPLE_PERIOD(SP), .DATA_FORMAT_VAL(8'h0B)
    ) dut (
        .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable),
        .o_spi_cs_n(o_spi_cs_n), .o_spi_sclk(o_spi_sclk), .o_spi_mosi(o_spi_mosi),
        .i_spi_miso(spi_miso), .o_axis_data(o_axis_data), .o_valid(o_valid),
        .o_init_done(o_init_done), .o_busy(o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // slave / monitor state
    logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_init = 1'b0;
    int mon_nfall = 0, mon_nrise = 0;
    logic [15:0] mosi_sh = '0, first16 = '0;
    logic [47:0] cur_bytes = '0;
    logic [47:0] want_q[$];
    logic [47:0] served_q[$];
    logic [47:0] val_q[$];
    logic val_cs_q[$];
    logic [15:0] txn_word_q[$];
    int txn_nfall_q[$];
    int csfall_q[$];
    int csrise_cyc = -1, init_rise_cyc = -2;
    int sclk_bad = 0, bad_valid = 0;

    always @(negedge clk) begin
        automatic logic cs_rose = (prev_cs === 1'b0) && (o_spi_cs_n === 1'b1);
        automatic logic cs_fell = (prev_cs === 1'b1) && (o_spi_cs_n === 1'b0);
        automatic int k;
        if (cs_fell) begin
            mon_nfall = 0;
            mon_nrise = 0;
            mosi_sh = '0;
            spi_miso = 1'b1;
            csfall_q.push_back(cyc);
        end else if (o_spi_cs_n === 1'b0) begin
            if (prev_sclk === 1'b1 && o_spi_sclk === 1'b0) begin
                k = mon_nfall - 8;
                if (k >= 0 && k < 48) spi_miso = cur_bytes[8*(k/8) + 7 - (k%8)];
                else spi_miso = 1'b1;
                mon_nfall++;
            end
            if (prev_sclk === 1'b0 && o_spi_sclk === 1'b1) begin
                mosi_sh = {mosi_sh[14:0], o_spi_mosi};
                mon_nrise++;
                if (mon_nrise == 8 && mosi_sh[7]) begin
                    if (want_q.size() > 0) cur_bytes = want_q.pop_front();
                    else cur_bytes = {16'($urandom), 32'($urandom)};
                    served_q.push_back(cur_bytes);
                end
                if (mon_nrise == 16) first16 = mosi_sh;
            end
        end
        if (cs_rose) begin
            txn_word_q.push_back(mon_nrise >= 16 ? first16 : mosi_sh);
            txn_nfall_q.push_back(mon_nfall);
            csrise_cyc = cyc;
        end
        if (o_init_done === 1'b1 && prev_init !== 1'b1) init_rise_cyc = cyc;
        if (o_spi_cs_n === 1'b1 && o_spi_sclk !== 1'b1) sclk_bad++;
        if (o_valid === 1'b1) begin
            val_q.push_back(o_axis_data);
            val_cs_q.push_back(cs_rose);
            if (o_init_done !== 1'b1) bad_valid++;
        end
        prev_cs = o_spi_cs_n;
        prev_sclk = o_spi_sclk;
        prev_init = o_init_done;
    end

    // reference: byte stream is X.lo X.hi Y.lo Y.hi Z.lo Z.hi
    function automatic int axis_word(input logic [47:0] b, input int n);
        return int'(b[8*(2*n+1) +: 8]) * 256 + int'(b[8*(2*n) +: 8]);
    endfunction

    function automatic logic [47:0] exp_raw(input logic [47:0] b);
        logic [47:0] r = '0;
        for (int n = 0; n < NA; n++) r[16*n +: 16] = 16'(axis_word(b, n));
        return r;
    endfunction

    function automatic logic [47:0] exp_avg(input logic [47:0] b0, b1, b2, b3);
        logic [47:0] r = '0;
        logic [47:0] rd[4];
        int s, w;
        rd[0] = b0; rd[1] = b1; rd[2] = b2; rd[3] = b3;
        for (int n = 0; n < NA; n++) begin
            s = 0;
            for (int i = 0; i < 4; i++) begin
                w = axis_word(rd[i], n);
                if (w >= 32768) w -= 65536;
                s += w;
            end
            s = s >>> 2;
            r[16*n +: 16] = 16'(s);
        end
        return r;
    endfunction

    task automatic clear_logs();
        want_q.delete(); served_q.delete(); val_q.delete(); val_cs_q.delete();
        txn_word_q.delete(); txn_nfall_q.delete(); csfall_q.delete();
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_enable = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++; if (o_spi_cs_n !== 1'b1) begin n_err++; $display("FAIL reset_cs: got %b want 1", o_spi_cs_n); end
        n_vec++; if (o_spi_sclk !== 1'b1) begin n_err++; $display("FAIL reset_sclk: got %b want 1", o_spi_sclk); end
        n_vec++; if (o_spi_mosi !== 1'b1) begin n_err++; $display("FAIL reset_mosi: got %b want 1", o_spi_mosi); end
        n_vec++; if (o_axis_data !== 48'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", o_axis_data); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_vec++; if (o_init_done !== 1'b0) begin n_err++; $display("FAIL reset_init: got %b want 0", o_init_done); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_init(input string tag);
        int t = 0;
        i_reset = 1'b0;
        while (o_init_done !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
        @(negedge clk);
        n_vec++; if (o_init_done !== 1'b1) begin n_err++; $display("FAIL %s_timeout: init_done %b want 1", tag, o_init_done); end
        n_vec++; if (txn_word_q.size() < 1 || txn_word_q[0] !== 16'h310B) begin
            n_err++; $display("FAIL %s_fmt_word: got %h want 310b", tag, txn_word_q.size() > 0 ? txn_word_q[0] : 16'hxxxx); end
        n_vec++; if (txn_word_q.size() < 2 || txn_word_q[1] !== 16'h2D08) begin
            n_err++; $display("FAIL %s_pwr_word: got %h want 2d08", tag, txn_word_q.size() > 1 ? txn_word_q[1] : 16'hxxxx); end
        n_vec++; if (txn_nfall_q.size() != 2 || txn_nfall_q[0] != 16 || txn_nfall_q[1] != 16) begin
            n_err++; $display("FAIL %s_write_len: %0d txns, want 2 of 16 edges", tag, txn_nfall_q.size()); end
        n_vec++; if (init_rise_cyc != csrise_cyc) begin
            n_err++; $display("FAIL %s_done_edge: init at %0d want cs rise %0d", tag, init_rise_cyc, csrise_cyc); end
        n_vec++; if (bad_valid != 0 || val_q.size() != 0) begin
            n_err++; $display("FAIL %s_valid_quiet: %0d pulses want 0", tag, val_q.size()); end
        n_vec++; if (sclk_bad != 0) begin
            n_err++; $display("FAIL %s_sclk_idle: %0d cycles sclk low with cs high, want 0", tag, sclk_bad); end
    endtask

`ifndef GSENSOR_POLLER_AVG_EN
    task automatic test_read_fixed();
        int t = 0;
        clear_logs();
        want_q.push_back(48'h0001ABCD1234);
        i_enable = 1'b1;
        while (val_q.size() < 1 && t < 2000) begin @(negedge clk); t++; end
        n_vec++; if (val_q.size() != 1) begin n_err++; $display("FAIL fixed_valid_count: got %0d want 1", val_q.size()); end
        else begin
            n_vec++; if (val_q[0] !== 48'h0001ABCD1234) begin
                n_err++; $display("FAIL fixed_data: got %h want 0001abcd1234", val_q[0]); end
            n_vec++; if (served_q.size() < 1 || val_q[0] !== exp_raw(served_q[0])) begin
                n_err++; $display("FAIL fixed_model: got %h", val_q[0]); end
            n_vec++; if (val_cs_q[0] !== 1'b1) begin n_err++; $display("FAIL fixed_valid_edge: got %b want 1", val_cs_q[0]); end
        end
        n_vec++; if (txn_word_q.size() < 1 || txn_word_q[0][15:8] !== 8'hF2) begin
            n_err++; $display("FAIL fixed_cmd: got %h want f2", txn_word_q.size() > 0 ? txn_word_q[0][15:8] : 8'hxx); end
        n_vec++; if (txn_nfall_q.size() < 1 || txn_nfall_q[0] != 56) begin
            n_err++; $display("FAIL fixed_len: got %0d want 56", txn_nfall_q.size() > 0 ? txn_nfall_q[0] : -1); end
    endtask
`else
    task automatic test_avg();
        int t = 0;
        logic [15:0] xa[8];
        xa = '{16'h0004, 16'h0005, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE};
        clear_logs();
        for (int i = 0; i < 8; i++) want_q.push_back({16'($urandom), 16'($urandom), xa[i]});
        i_enable = 1'b1;
        while (val_q.size() < 1 && t < 2500) begin @(negedge clk); t++; end
        n_vec++; if (val_q.size() != 1 || served_q.size() != 4) begin
            n_err++; $display("FAIL avg_rate: %0d pulses after %0d reads, want 1 after 4", val_q.size(), served_q.size()); end
        else begin
            n_vec++; if (val_q[0][15:0] !== 16'h0002) begin n_err++; $display("FAIL avg_x1: got %h want 0002", val_q[0][15:0]); end
            n_vec++; if (val_q[0] !== exp_avg(served_q[0], served_q[1], served_q[2], served_q[3])) begin
                n_err++; $display("FAIL avg_model1: got %h", val_q[0]); end
            n_vec++; if (val_cs_q[0] !== 1'b1) begin n_err++; $display("FAIL avg_edge: got %b want 1", val_cs_q[0]); end
        end
        t = 0;
        while (val_q.size() < 2 && t < 2500) begin @(negedge clk); t++; end
        n_vec++; if (val_q.size() != 2 || served_q.size() < 8) begin
            n_err++; $display("FAIL avg_second: %0d pulses, %0d reads, want 2 and 8", val_q.size(), served_q.size()); end
        else begin
            n_vec++; if (val_q[1][15:0] !== 16'hFFFE) begin n_err++; $display("FAIL avg_x2: got %h want fffe", val_q[1][15:0]); end
            n_vec++; if (val_q[1] !== exp_avg(served_q[4], served_q[5], served_q[6], served_q[7])) begin
                n_err++; $display("FAIL avg_model2: got %h", val_q[1]); end
        end
    endtask
`endif

    task automatic test_period();
        int t = 0;
        int r0 = txn_nfall_q.size();
        while (txn_nfall_q.size() == r0 && t < 1000) begin @(negedge clk); t++; end
        clear_logs();
        t = 0;
        while (csfall_q.size() < 5 && t < 3000) begin @(negedge clk); t++; end
        n_vec++; if (csfall_q.size() < 5) begin n_err++; $display("FAIL period_timeout: %0d reads want 5", csfall_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++; if (csfall_q[i+1] - csfall_q[i] != SP) begin
                    n_err++; $display("FAIL period_gap%0d: got %0d want %0d", i, csfall_q[i+1] - csfall_q[i], SP); end
            end
        end
`ifndef GSENSOR_POLLER_AVG_EN
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (val_q.size() <= i || served_q.size() <= i || val_q[i] !== exp_raw(served_q[i]) || val_cs_q[i] !== 1'b1) begin
                n_err++; $display("FAIL period_data%0d: got %h want %h", i,
                    val_q.size() > i ? val_q[i] : 48'hx, served_q.size() > i ? exp_raw(served_q[i]) : 48'hx); end
        end
`endif
    endtask

    task automatic test_enable_gate();
        int t = 0;
        int n0 = csfall_q.size();
        int v0, r0, f0;
        while (csfall_q.size() == n0 && t < 1000) begin @(negedge clk); t++; end
        repeat (10) @(negedge clk);
        i_enable = 1'b0;
        v0 = val_q.size();
        r0 = txn_nfall_q.size();
        t = 0;
        while (txn_nfall_q.size() == r0 && t < 1000) begin @(negedge clk); t++; end
        n_vec++; if (txn_nfall_q.size() == r0) begin n_err++; $display("FAIL gate_finish: read never completed"); end
`ifndef GSENSOR_POLLER_AVG_EN
        n_vec++; if (val_q.size() != v0 + 1 || served_q.size() <= v0 || val_q[v0] !== exp_raw(served_q[v0])) begin
            n_err++; $display("FAIL gate_valid: %0d pulses want %0d", val_q.size(), v0 + 1); end
`endif
        f0 = csfall_q.size();
        repeat (1000) @(negedge clk);
        n_vec++; if (csfall_q.size() != f0) begin
            n_err++; $display("FAIL gate_idle: %0d reads while disabled want 0", csfall_q.size() - f0); end
        i_enable = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (o_spi_cs_n !== 1'b0) begin n_err++; $display("FAIL gate_resume: cs %b want 0", o_spi_cs_n); end
    endtask

    task automatic test_reset_mid_read();
        int t = 0;
        repeat (2) @(negedge clk);
        while (mon_nrise < 20 && t < 500) begin @(negedge clk); t++; end
        n_vec++; if (o_spi_cs_n !== 1'b0) begin n_err++; $display("FAIL midrst_inread: cs %b want 0", o_spi_cs_n); end
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (o_spi_cs_n !== 1'b1) begin n_err++; $display("FAIL midrst_cs: got %b want 1", o_spi_cs_n); end
        n_vec++; if (o_spi_sclk !== 1'b1) begin n_err++; $display("FAIL midrst_sclk: got %b want 1", o_spi_sclk); end
        n_vec++; if (o_init_done !== 1'b0) begin n_err++; $display("FAIL midrst_init: got %b want 0", o_init_done); end
        n_vec++; if (o_axis_data !== 48'h0) begin n_err++; $display("FAIL midrst_data: got %h want 0", o_axis_data); end
        repeat (3) @(negedge clk);
        clear_logs();
        bad_valid = 0;
        test_init("reinit");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init("init");
`ifndef GSENSOR_POLLER_AVG_EN
        test_read_fixed();
`else
        test_avg();
`endif
        test_period();
        test_enable_gate();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
